// File: rtl/sweep_pkg.sv
// Shared state encoding and constants for the sweep sequencer and its phase averager.
package sweep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RETUNE,
        SETTLE,
        ACQ,
        REPORT,
        NEXT,
        FIN
    } state_e;

    localparam int PH_MAX        = 18000;
    localparam int AVG_LOG2_MAX  = 8;
    localparam int RETUNE_CYCLES = 2;

    function automatic logic [3:0] clamp_avg_log2(input logic [3:0] k);
        return (k > 4'(AVG_LOG2_MAX)) ? 4'(AVG_LOG2_MAX) : k;
    endfunction

endpackage

// File: rtl/phase_averager.sv
// Accumulates 2^k phase samples, produces the floored mean and compares its
// magnitude against the current best point.
module phase_averager
    import sweep_pkg::*;
#(
    parameter int PH_W  = 16,
    parameter int ACC_W = PH_W + 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [3:0]             k_i,
    input  logic signed [PH_W-1:0] phase_i,
    input  logic                   valid_i,
    input  logic signed [PH_W-1:0] best_i,
    output logic                   last_o,
    output logic signed [PH_W-1:0] mean_o,
    output logic                   better_o
);

    localparam int CNT_W = AVG_LOG2_MAX + 1;

    logic signed [ACC_W-1:0] acc_q, acc_d, shifted;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_last;
    logic signed [PH_W-1:0]  mean_q;
    logic                    take;

    // The most negative code has no positive twin, so it saturates.
    function automatic logic [PH_W-1:0] abs_sat(input logic signed [PH_W-1:0] x);
        if (x == {1'b1, {(PH_W-1){1'b0}}})
            return {1'b0, {(PH_W-1){1'b1}}};
        return x[PH_W-1] ? PH_W'(-x) : x;
    endfunction

    always_comb begin
        take     = en_i & valid_i;
        cnt_last = (CNT_W'(1) << k_i) - CNT_W'(1);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (take) begin
            acc_d = acc_q + {{(ACC_W-PH_W){phase_i[PH_W-1]}}, phase_i};
            cnt_d = cnt_q + CNT_W'(1);
        end
        last_o  = take & (cnt_q == cnt_last);
        shifted = acc_d >>> k_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            mean_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (last_o)
                mean_q <= shifted[PH_W-1:0];
        end
    end

    assign mean_o   = mean_q;
    assign better_o = abs_sat(mean_q) < abs_sat(best_i);

endmodule

// File: rtl/sweep_sequencer.sv
// Steps an NCO tuning word across a range, averages phase at each point and
// tracks the minimum-|phase| point. SWEEP_ZERO_CROSS_EN adds early stop on sign change.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int FTW_W = 32,
    parameter int PH_W  = 16,
    parameter int IDX_W = 12,
    parameter int SET_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [FTW_W-1:0]       cfg_start_ftw,
    input  logic [FTW_W-1:0]       cfg_step_ftw,
    input  logic [IDX_W-1:0]       cfg_num_steps,
    input  logic [SET_W-1:0]       cfg_settle,
    input  logic [3:0]             cfg_avg_log2,
    input  logic signed [PH_W-1:0] phase_in,
    input  logic                   phase_valid_in,
    output logic [FTW_W-1:0]       ftw_out,
    output logic                   ftw_load,
    output logic                   pd_reset,
    output logic                   res_valid,
    output logic [IDX_W-1:0]       res_idx,
    output logic signed [PH_W-1:0] res_phase,
    output logic [FTW_W-1:0]       best_ftw,
    output logic signed [PH_W-1:0] best_phase,
    output logic                   busy,
`ifdef SWEEP_ZERO_CROSS_EN
    output logic                   zc_hit,
`endif
    output logic                   done
);

    state_e                 state_q;
    logic [FTW_W-1:0]       step_q, ftw_q, best_ftw_q;
    logic [IDX_W-1:0]       last_idx_q, idx_q, res_idx_q;
    logic [SET_W-1:0]       settle_q, cnt_q;
    logic [3:0]             k_q;
    logic                   ftw_load_q, pd_reset_q, res_valid_q, busy_q, done_q;
    logic signed [PH_W-1:0] best_phase_q;
    logic signed [PH_W-1:0] avg_mean;
    logic                   avg_last, avg_better, zc_stop;

    // Accumulator is cleared throughout RETUNE, which always precedes ACQ.
    phase_averager #(.PH_W(PH_W)) u_avg (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (state_q == RETUNE),
        .en_i     (state_q == ACQ),
        .k_i      (k_q),
        .phase_i  (phase_in),
        .valid_i  (phase_valid_in),
        .best_i   (best_phase_q),
        .last_o   (avg_last),
        .mean_o   (avg_mean),
        .better_o (avg_better)
    );

`ifdef SWEEP_ZERO_CROSS_EN
    logic prev_neg_q, zc_hit_q;
    assign zc_stop = (idx_q != '0) && (avg_mean[PH_W-1] != prev_neg_q);
    assign zc_hit  = zc_hit_q;
`else
    assign zc_stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            step_q       <= '0;
            ftw_q        <= '0;
            best_ftw_q   <= '0;
            last_idx_q   <= '0;
            idx_q        <= '0;
            res_idx_q    <= '0;
            settle_q     <= '0;
            cnt_q        <= '0;
            k_q          <= '0;
            ftw_load_q   <= 1'b0;
            pd_reset_q   <= 1'b1;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            best_phase_q <= PH_W'(PH_MAX);
`ifdef SWEEP_ZERO_CROSS_EN
            prev_neg_q   <= 1'b0;
            zc_hit_q     <= 1'b0;
`endif
        end else begin
            ftw_load_q  <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (abort && state_q != IDLE && state_q != FIN) begin
                state_q    <= FIN;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                pd_reset_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            step_q       <= cfg_step_ftw;
                            settle_q     <= cfg_settle;
                            k_q          <= clamp_avg_log2(cfg_avg_log2);
                            last_idx_q   <= (cfg_num_steps == '0) ? '0 : cfg_num_steps - IDX_W'(1);
                            idx_q        <= '0;
                            ftw_q        <= cfg_start_ftw;
                            ftw_load_q   <= 1'b1;
                            best_ftw_q   <= '0;
                            best_phase_q <= PH_W'(PH_MAX);
                            busy_q       <= 1'b1;
                            pd_reset_q   <= 1'b1;
                            cnt_q        <= '0;
                            state_q      <= RETUNE;
`ifdef SWEEP_ZERO_CROSS_EN
                            zc_hit_q     <= 1'b0;
`endif
                        end
                    end
                    RETUNE: begin
                        if (cnt_q == SET_W'(RETUNE_CYCLES - 1)) begin
                            pd_reset_q <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= (settle_q == '0) ? ACQ : SETTLE;
                        end else begin
                            cnt_q <= cnt_q + SET_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (cnt_q == settle_q - SET_W'(1))
                            state_q <= ACQ;
                        else
                            cnt_q <= cnt_q + SET_W'(1);
                    end
                    ACQ: begin
                        if (avg_last) begin
                            res_valid_q <= 1'b1;
                            res_idx_q   <= idx_q;
                            state_q     <= REPORT;
                        end
                    end
                    REPORT: begin
                        if (avg_better) begin
                            best_ftw_q   <= ftw_q;
                            best_phase_q <= avg_mean;
                        end
`ifdef SWEEP_ZERO_CROSS_EN
                        prev_neg_q <= avg_mean[PH_W-1];
                        if (zc_stop)
                            zc_hit_q <= 1'b1;
`endif
                        if (idx_q == last_idx_q || zc_stop) begin
                            state_q    <= FIN;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            pd_reset_q <= 1'b1;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                    NEXT: begin
                        idx_q      <= idx_q + IDX_W'(1);
                        ftw_q      <= ftw_q + step_q;
                        ftw_load_q <= 1'b1;
                        pd_reset_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= RETUNE;
                    end
                    FIN:     state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ftw_out    = ftw_q;
    assign ftw_load   = ftw_load_q;
    assign pd_reset   = pd_reset_q;
    assign res_valid  = res_valid_q;
    assign res_idx    = res_idx_q;
    assign res_phase  = avg_mean;
    assign best_ftw   = best_ftw_q;
    assign best_phase = best_phase_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer: one task per scenario with inline checks.
module tb_sweep_sequencer;

    logic               clk = 1'b0;
    logic               reset;
    logic               start, abort;
    logic [31:0]        cfg_start_ftw, cfg_step_ftw;
    logic [11:0]        cfg_num_steps;
    logic [15:0]        cfg_settle;
    logic [3:0]         cfg_avg_log2;
    logic signed [15:0] phase_in;
    logic               phase_valid_in;
    logic [31:0]        ftw_out, best_ftw;
    logic               ftw_load, pd_reset, res_valid, busy, done;
    logic [11:0]        res_idx;
    logic signed [15:0] res_phase, best_phase;
`ifdef SWEEP_ZERO_CROSS_EN
    logic               zc_hit;
`endif

    sweep_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .cfg_start_ftw  (cfg_start_ftw),
        .cfg_step_ftw   (cfg_step_ftw),
        .cfg_num_steps  (cfg_num_steps),
        .cfg_settle     (cfg_settle),
        .cfg_avg_log2   (cfg_avg_log2),
        .phase_in       (phase_in),
        .phase_valid_in (phase_valid_in),
        .ftw_out        (ftw_out),
        .ftw_load       (ftw_load),
        .pd_reset       (pd_reset),
        .res_valid      (res_valid),
        .res_idx        (res_idx),
        .res_phase      (res_phase),
        .best_ftw       (best_ftw),
        .best_phase     (best_phase),
        .busy           (busy),
`ifdef SWEEP_ZERO_CROSS_EN
        .zc_hit         (zc_hit),
`endif
        .done           (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic signed [15:0] samp_mem [0:511];

    // Transaction log captured on the falling edge.
    logic [31:0]        ftw_log [0:15];
    int                 ftw_cyc [0:15];
    logic [11:0]        idx_log [0:15];
    logic signed [15:0] ph_log  [0:15];
    int                 res_cnt  = 0;
    int                 ftw_cnt  = 0;
    int                 done_cnt = 0;
    int                 cyc      = 0;
    logic               log_clr  = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (log_clr) begin
            res_cnt  <= 0;
            ftw_cnt  <= 0;
            done_cnt <= 0;
        end else begin
            if (res_valid) begin
                $display("res idx=%0d phase=%0d", res_idx, res_phase);
                if (res_cnt < 16) begin
                    idx_log[res_cnt] <= res_idx;
                    ph_log[res_cnt]  <= res_phase;
                end
                res_cnt <= res_cnt + 1;
            end
            if (ftw_load) begin
                $display("ftw_load ftw=%08h", ftw_out);
                if (ftw_cnt < 16) begin
                    ftw_log[ftw_cnt] <= ftw_out;
                    ftw_cyc[ftw_cnt] <= cyc;
                end
                ftw_cnt <= ftw_cnt + 1;
            end
            if (done) begin
                $display("done");
                done_cnt <= done_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_clr = 1'b1;
        @(negedge clk);
        #1;
        log_clr = 1'b0;
    endtask

    task automatic start_sweep(input logic [31:0] sf, input logic [31:0] st, input int n,
                               input int settle, input int avg);
        clear_log();
        cfg_start_ftw = sf;
        cfg_step_ftw  = st;
        cfg_num_steps = 12'(n);
        cfg_settle    = 16'(settle);
        cfg_avg_log2  = 4'(avg);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pd(input logic val, output bit ok);
        int guard = 0;
        while (pd_reset !== val && guard < 4000) begin
            tick();
            guard++;
        end
        ok = (guard < 4000);
    endtask

    // Feeds junk valids during SETTLE, then nsamp samples from samp_mem.
    task automatic run_point(input int settle, input int nsamp);
        bit ok1, ok2;
        wait_pd(1'b1, ok1);
        wait_pd(1'b0, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            failures++;
            $display("FAIL run_point_sync got=timeout exp=pd_reset_toggle");
        end else begin
            for (int i = 0; i < settle; i++) begin
                phase_valid_in = 1'b1;
                phase_in       = 16'sd7777;
                tick();
            end
            for (int i = 0; i < nsamp; i++) begin
                phase_valid_in = 1'b1;
                phase_in       = samp_mem[i];
                tick();
            end
        end
        phase_valid_in = 1'b0;
        phase_in       = '0;
    endtask

    task automatic wait_done(input string name);
        int guard = 0;
        while (done !== 1'b1 && guard < 3000) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 3000) begin
            failures++;
            $display("FAIL %s_done got=timeout exp=done_pulse", name);
        end else begin
            checks++;
            if ({busy, pd_reset} !== 2'b01) begin
                failures++;
                $display("FAIL %s_fin_flags got busy,pd=%b exp=01", name, {busy, pd_reset});
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_start_ftw = '0;
        cfg_step_ftw  = '0;
        cfg_num_steps = '0;
        cfg_settle    = '0;
        cfg_avg_log2  = '0;
        phase_in       = '0;
        phase_valid_in = 1'b0;
        repeat (3) tick();
        for (int r = 0; r < 2; r++) begin
            checks++;
            if ({ftw_load, pd_reset, res_valid, busy, done} !== 5'b01000) begin
                failures++;
                $display("FAIL reset_flags pass=%0d got=%b exp=01000", r, {ftw_load, pd_reset, res_valid, busy, done});
            end
            checks++;
            if (ftw_out !== 32'h0 || best_ftw !== 32'h0 || res_idx !== 12'h0 || res_phase !== 16'sd0) begin
                failures++;
                $display("FAIL reset_values got ftw=%h best_ftw=%h idx=%0d ph=%0d exp=0", ftw_out, best_ftw, res_idx, res_phase);
            end
            checks++;
            if (best_phase !== 16'sd18000) begin
                failures++;
                $display("FAIL reset_best_phase got=%0d exp=18000", best_phase);
            end
`ifdef SWEEP_ZERO_CROSS_EN
            checks++;
            if (zc_hit !== 1'b0) begin
                failures++;
                $display("FAIL reset_zc_hit got=%b exp=0", zc_hit);
            end
`endif
            reset = 1'b1;
            tick();
        end
    endtask

    task automatic test_basic();
        start_sweep(32'h1000, 32'h100, 4, 10, 2);
        checks++;
        if ({busy, ftw_load} !== 2'b11 || ftw_out !== 32'h1000) begin
            failures++;
            $display("FAIL basic_start got busy,load=%b ftw=%h exp=11 1000", {busy, ftw_load}, ftw_out);
        end
        // A second start and new cfg mid-sweep must be ignored.
        cfg_start_ftw = 32'hDEAD0000;
        cfg_step_ftw  = 32'h5;
        cfg_num_steps = 12'd1;
        cfg_settle    = 16'd1;
        cfg_avg_log2  = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 4; i++) samp_mem[i] = 16'sd500;
            run_point(10, 4);
        end
        wait_done("basic");
        checks++;
        if (res_cnt !== 4 || ftw_cnt !== 4 || done_cnt !== 1) begin
            failures++;
            $display("FAIL basic_counts got res=%0d ftw=%0d done=%0d exp=4 4 1", res_cnt, ftw_cnt, done_cnt);
        end
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (idx_log[p] !== 12'(p) || ph_log[p] !== 16'sd500) begin
                failures++;
                $display("FAIL basic_res%0d got idx=%0d ph=%0d exp=%0d 500", p, idx_log[p], ph_log[p], p);
            end
            checks++;
            if (ftw_log[p] !== 32'h1000 + 32'(p) * 32'h100) begin
                failures++;
                $display("FAIL basic_ftw%0d got=%h exp=%h", p, ftw_log[p], 32'h1000 + 32'(p) * 32'h100);
            end
        end
        checks++;
        if (ftw_cyc[1] - ftw_cyc[0] !== 18) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=18", ftw_cyc[1] - ftw_cyc[0]);
        end
        checks++;
        if (best_ftw !== 32'h1000 || best_phase !== 16'sd500) begin
            failures++;
            $display("FAIL basic_best got ftw=%h ph=%0d exp=1000 500", best_ftw, best_phase);
        end
    endtask

`ifndef SWEEP_ZERO_CROSS_EN
    task automatic test_best_tie();
        int ph_tab [4] = '{3000, -200, 150, -150};
        start_sweep(32'h2000, 32'h10, 4, 3, 0);
        for (int p = 0; p < 4; p++) begin
            samp_mem[0] = 16'(ph_tab[p]);
            run_point(3, 1);
        end
        wait_done("best");
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (ph_log[p] !== 16'(ph_tab[p])) begin
                failures++;
                $display("FAIL best_res%0d got=%0d exp=%0d", p, ph_log[p], ph_tab[p]);
            end
        end
        checks++;
        if (best_phase !== 16'sd150 || best_ftw !== 32'h2020) begin
            failures++;
            $display("FAIL best_tie got ph=%0d ftw=%h exp=150 2020", best_phase, best_ftw);
        end
    endtask
`endif

    task automatic test_floor_avg();
        start_sweep(32'h0, 32'h0, 1, 2, 2);
        samp_mem[0] = -16'sd3;
        samp_mem[1] = -16'sd3;
        samp_mem[2] = -16'sd3;
        samp_mem[3] = -16'sd2;
        run_point(2, 4);
        wait_done("floor");
        checks++;
        if (res_cnt !== 1 || ph_log[0] !== -16'sd3) begin
            failures++;
            $display("FAIL floor_avg got cnt=%0d ph=%0d exp=1 -3", res_cnt, ph_log[0]);
        end
        // k=12 clamps to 8: only the first 256 samples may count.
        start_sweep(32'h0, 32'h0, 1, 0, 12);
        for (int i = 0; i < 255; i++) samp_mem[i] = 16'sd0;
        samp_mem[255] = 16'sd256;
        samp_mem[256] = 16'sd25600;
        run_point(0, 257);
        wait_done("clamp");
        checks++;
        if (res_cnt !== 1 || ph_log[0] !== 16'sd1) begin
            failures++;
            $display("FAIL clamp_avg got cnt=%0d ph=%0d exp=1 1", res_cnt, ph_log[0]);
        end
    endtask

    task automatic test_abort();
        bit ok1, ok2;
        start_sweep(32'h3000, 32'h40, 4, 5, 0);
        samp_mem[0] = 16'sd100;
        run_point(5, 1);
        samp_mem[0] = 16'sd50;
        run_point(5, 1);
        wait_pd(1'b1, ok1);
        wait_pd(1'b0, ok2);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (!(ok1 && ok2) || {done, busy, pd_reset, res_valid} !== 4'b1010) begin
            failures++;
            $display("FAIL abort_fin got done,busy,pd,rv=%b sync=%b exp=1010", {done, busy, pd_reset, res_valid}, ok1 && ok2);
        end
        tick();
        tick();
        checks++;
        if (res_cnt !== 2 || done_cnt !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_counts got res=%0d done=%0d busy=%b exp=2 1 0", res_cnt, done_cnt, busy);
        end
        checks++;
        if (best_phase !== 16'sd50 || best_ftw !== 32'h3040) begin
            failures++;
            $display("FAIL abort_best got ph=%0d ftw=%h exp=50 3040", best_phase, best_ftw);
        end
    endtask

    task automatic test_wrap_and_n0();
        start_sweep(32'hFFFFFF00, 32'h200, 2, 0, 0);
        samp_mem[0] = 16'sd10;
        run_point(0, 1);
        run_point(0, 1);
        wait_done("wrap");
        checks++;
        if (ftw_cnt !== 2 || ftw_log[1] !== 32'h00000100) begin
            failures++;
            $display("FAIL wrap_ftw got cnt=%0d ftw=%h exp=2 00000100", ftw_cnt, ftw_log[1]);
        end
        start_sweep(32'h55, 32'h1, 0, 0, 0);
        run_point(0, 1);
        wait_done("n0");
        tick();
        checks++;
        if (res_cnt !== 1 || ftw_cnt !== 1 || done_cnt !== 1) begin
            failures++;
            $display("FAIL n0_points got res=%0d ftw=%0d done=%0d exp=1 1 1", res_cnt, ftw_cnt, done_cnt);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        start_sweep(32'h7000, 32'h1, 4, 0, 3);
        wait_pd(1'b1, ok);
        wait_pd(1'b0, ok);
        for (int i = 0; i < 3; i++) begin
            phase_valid_in = 1'b1;
            phase_in       = 16'sd100;
            tick();
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (!ok || {ftw_load, pd_reset, res_valid, busy, done} !== 5'b01000 || ftw_out !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_flags got=%b ftw=%h exp=01000 0", {ftw_load, pd_reset, res_valid, busy, done}, ftw_out);
        end
        checks++;
        if (best_phase !== 16'sd18000 || best_ftw !== 32'h0) begin
            failures++;
            $display("FAIL async_reset_best got ph=%0d ftw=%h exp=18000 0", best_phase, best_ftw);
        end
        phase_valid_in = 1'b0;
        phase_in       = '0;
        tick();
        reset = 1'b1;
        tick();
        start_sweep(32'h10, 32'h0, 1, 0, 0);
        samp_mem[0] = -16'sd42;
        run_point(0, 1);
        wait_done("recover");
        checks++;
        if (res_cnt !== 1 || ph_log[0] !== -16'sd42 || best_phase !== -16'sd42) begin
            failures++;
            $display("FAIL recover_point got cnt=%0d ph=%0d best=%0d exp=1 -42 -42", res_cnt, ph_log[0], best_phase);
        end
    endtask

`ifdef SWEEP_ZERO_CROSS_EN
    task automatic test_zero_cross();
        int ph_tab [3] = '{400, 100, -50};
        start_sweep(32'h100, 32'h100, 4, 1, 0);
        for (int p = 0; p < 3; p++) begin
            samp_mem[0] = 16'(ph_tab[p]);
            run_point(1, 1);
        end
        wait_done("zc");
        checks++;
        if (res_cnt !== 3 || zc_hit !== 1'b1) begin
            failures++;
            $display("FAIL zc_stop got cnt=%0d zc=%b exp=3 1", res_cnt, zc_hit);
        end
        checks++;
        if (best_phase !== -16'sd50 || best_ftw !== 32'h300) begin
            failures++;
            $display("FAIL zc_best got ph=%0d ftw=%h exp=-50 300", best_phase, best_ftw);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
`ifndef SWEEP_ZERO_CROSS_EN
        test_best_tie();
`endif
        test_floor_avg();
        test_abort();
        test_wrap_and_n0();
        test_async_reset();
`ifdef SWEEP_ZERO_CROSS_EN
        test_zero_cross();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
